router_fsm_np: RTL and testbench

Parametrised packet-router control FSM for a 1×N router, the generalised successor to the fixed 1×3 router controller. It sits between the input register block, the synchroniser and the N output FIFOs. It decodes the header address, sequences header, payload and parity loading, and stalls on FIFO full. Adds N-wide channel vectors, a latched destination output, and optional dropping of packets addressed to non-existent ports.

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_fsm_np.sv | 120 ++++++++++++
 tb/tb_router_fsm_np.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types for the 1xN router control FSM.
// The DROP_PACKET state exists only when ROUTER_FSM_DROP_INVALID_EN is defined.
package router_pkg;

  localparam int MAX_PORTS = 16;

  typedef enum logic [3:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
`ifdef ROUTER_FSM_DROP_INVALID_EN
    , DROP_PACKET
`endif
  } router_state_t;

endpackage

// File: rtl/router_fsm_np.sv
// 1xN packet-router control FSM: header decode, load sequencing, FIFO-full stall.
// Define ROUTER_FSM_DROP_INVALID_EN to discard packets addressed to absent ports.
module router_fsm_np
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_packet_valid,
  output logic                 write_enb_reg,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 busy,
  output logic [ADDR_W-1:0]    dest_sel,
  output logic                 drop_state
);

  localparam logic [ADDR_W:0] PORT_LIMIT = (ADDR_W+1)'(NUM_PORTS);

  router_state_t state;
  router_state_t nxt;
  logic          addr_ok;
  logic          sel_soft_reset;
  logic          soft_reset_armed;

  assign addr_ok        = {1'b0, data_in} < PORT_LIMIT;
  assign sel_soft_reset = soft_reset[dest_sel];

`ifdef ROUTER_FSM_DROP_INVALID_EN
  assign soft_reset_armed = (state != DECODE_ADDRESS) && (state != DROP_PACKET);
`else
  assign soft_reset_armed = (state != DECODE_ADDRESS);
`endif

  always_comb begin
    nxt = state;
    if (soft_reset_armed && sel_soft_reset) begin
      nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid && addr_ok)
            nxt = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
`ifdef ROUTER_FSM_DROP_INVALID_EN
          else if (pkt_valid)
            nxt = DROP_PACKET;
`endif
        end
        LOAD_FIRST_DATA: nxt = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       nxt = FIFO_FULL_STATE;
          else if (!pkt_valid) nxt = LOAD_PARITY;
        end
        FIFO_FULL_STATE: if (!fifo_full) nxt = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (parity_done)           nxt = DECODE_ADDRESS;
          else if (low_packet_valid) nxt = LOAD_PARITY;
          else                       nxt = LOAD_DATA;
        end
        LOAD_PARITY:        nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:    if (fifo_empty[dest_sel]) nxt = LOAD_FIRST_DATA;
`ifdef ROUTER_FSM_DROP_INVALID_EN
        DROP_PACKET:        if (!pkt_valid) nxt = DECODE_ADDRESS;
`endif
        default:            nxt = DECODE_ADDRESS;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= DECODE_ADDRESS;
      dest_sel      <= '0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state <= nxt;
      if (state == DECODE_ADDRESS && pkt_valid && addr_ok)
        dest_sel <= data_in;
      detect_add    <= (nxt == DECODE_ADDRESS);
      lfd_state     <= (nxt == LOAD_FIRST_DATA);
      ld_state      <= (nxt == LOAD_DATA);
      laf_state     <= (nxt == LOAD_AFTER_FULL);
      full_state    <= (nxt == FIFO_FULL_STATE);
      rst_int_reg   <= (nxt == CHECK_PARITY_ERROR);
      write_enb_reg <= (nxt == LOAD_DATA) || (nxt == LOAD_PARITY) || (nxt == LOAD_AFTER_FULL);
      busy          <= (nxt != DECODE_ADDRESS) && (nxt != LOAD_DATA);
    end
  end

`ifdef ROUTER_FSM_DROP_INVALID_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) drop_state <= 1'b0;
    else       drop_state <= (nxt == DROP_PACKET);
  end
`else
  assign drop_state = 1'b0;
`endif

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed bench for router_fsm_np: 3-port instance plus a 5-port/3-bit-address instance.
// Drop-path expectations follow ROUTER_FSM_DROP_INVALID_EN.
module tb_router_fsm_np;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, pkt_valid, fifo_full, parity_done, low_packet_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_empty, soft_reset;
  logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, busy, drop_state;
  logic [1:0] dest_sel;

  logic       reset5, pkt_valid5;
  logic [2:0] data_in5;
  logic [4:0] fifo_empty5;
  logic       web5, da5, lfd5, ld5, laf5, ff5, rir5, busy5, drop5;
  logic [2:0] dest_sel5;

  router_fsm_np #(.NUM_PORTS(3), .ADDR_W(2)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_packet_valid(low_packet_valid),
    .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy), .dest_sel(dest_sel), .drop_state(drop_state)
  );

  router_fsm_np #(.NUM_PORTS(5), .ADDR_W(3)) dut5 (
    .clock(clock), .reset(reset5), .pkt_valid(pkt_valid5), .data_in(data_in5),
    .fifo_full(1'b0), .fifo_empty(fifo_empty5), .soft_reset(5'b0),
    .parity_done(1'b0), .low_packet_valid(1'b0),
    .write_enb_reg(web5), .detect_add(da5), .lfd_state(lfd5),
    .ld_state(ld5), .laf_state(laf5), .full_state(ff5),
    .rst_int_reg(rir5), .busy(busy5), .dest_sel(dest_sel5), .drop_state(drop5)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; data_in = '0; fifo_full = 1'b0;
    fifo_empty = '0; soft_reset = '0; parity_done = 1'b0; low_packet_valid = 1'b0;
    reset5 = 1'b1; pkt_valid5 = 1'b0; data_in5 = '0; fifo_empty5 = '0;
    tick(); tick();
    check("rst_detect_add", detect_add, 1);
    check("rst_busy", busy, 0);
    check("rst_dest_sel", dest_sel, 0);
    check("rst_write_enb", write_enb_reg, 0);
    check("rst_drop", drop_state, 0);
    reset = 1'b0; reset5 = 1'b0;

    // packet to port 0 with a two-cycle FIFO-full stall
    pkt_valid = 1'b1; data_in = 2'd0; fifo_empty = 3'b001;
    tick();
    check("p0_lfd", lfd_state, 1);
    check("p0_lfd_busy", busy, 1);
    check("p0_dest_sel", dest_sel, 0);
    tick();
    check("p0_ld", ld_state, 1);
    check("p0_ld_web", write_enb_reg, 1);
    check("p0_ld_busy", busy, 0);
    fifo_full = 1'b1;
    tick();
    check("p0_ffs1", full_state, 1);
    check("p0_ffs1_busy", busy, 1);
    tick();
    check("p0_ffs2", full_state, 1);
    fifo_full = 1'b0; low_packet_valid = 1'b1;
    tick();
    check("p0_laf", laf_state, 1);
    check("p0_laf_web", write_enb_reg, 1);
    tick();
    check("p0_lp_web", write_enb_reg, 1);
    check("p0_lp_busy", busy, 1);
    check("p0_lp_not_ld", ld_state, 0);
    low_packet_valid = 1'b0; pkt_valid = 1'b0;
    tick();
    check("p0_cpe", rst_int_reg, 1);
    tick();
    check("p0_da", detect_add, 1);
    check("p0_da_rir", rst_int_reg, 0);

    // port 2 busy: wait till empty, then full and !pkt_valid together in LD
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b000;
    tick();
    check("p2_wte_busy", busy, 1);
    check("p2_wte_da", detect_add, 0);
    check("p2_wte_web", write_enb_reg, 0);
    check("p2_dest_sel", dest_sel, 2);
    tick();
    check("p2_wte_hold", busy, 1);
    fifo_empty = 3'b100;
    tick();
    check("p2_lfd", lfd_state, 1);
    tick();
    check("p2_ld", ld_state, 1);
    pkt_valid = 1'b0; fifo_full = 1'b1;
    tick();
    check("p2_full_wins", full_state, 1);
    fifo_full = 1'b0;
    tick();
    check("p2_laf", laf_state, 1);
    parity_done = 1'b1;
    tick();
    check("p2_parity_done_da", detect_add, 1);
    parity_done = 1'b0;

    // soft reset on unselected then selected channel
    pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b010;
    tick(); tick();
    check("p1_ld", ld_state, 1);
    check("p1_dest_sel", dest_sel, 1);
    soft_reset = 3'b001;
    tick();
    check("sr_other_ignored", ld_state, 1);
    soft_reset = 3'b010;
    tick();
    check("sr_sel_da", detect_add, 1);
    check("sr_dest_hold", dest_sel, 1);
    soft_reset = 3'b000; pkt_valid = 1'b0;
    tick();

    // invalid address 3
    pkt_valid = 1'b1; data_in = 2'd3;
    tick();
`ifdef ROUTER_FSM_DROP_INVALID_EN
    check("drop_state", drop_state, 1);
    check("drop_busy", busy, 1);
    check("drop_web", write_enb_reg, 0);
    tick();
    check("drop_hold", drop_state, 1);
    check("drop_hold_web", write_enb_reg, 0);
    pkt_valid = 1'b0;
    tick();
    check("drop_exit_da", detect_add, 1);
    check("drop_exit_flag", drop_state, 0);
`else
    check("inv_da", detect_add, 1);
    check("inv_busy", busy, 0);
    check("inv_drop", drop_state, 0);
    tick();
    check("inv_da_hold", detect_add, 1);
    pkt_valid = 1'b0;
`endif
    check("inv_dest_hold", dest_sel, 1);

    // 5-port instance: route to port 4, then async reset mid-LD
    pkt_valid5 = 1'b1; data_in5 = 3'd4; fifo_empty5 = 5'b10000;
    tick();
    check("n5_lfd", lfd5, 1);
    check("n5_dest_sel", dest_sel5, 4);
    tick();
    check("n5_ld", ld5, 1);
    #2 reset5 = 1'b1;
    #1;
    check("n5_rst_da", da5, 1);
    check("n5_rst_dest", dest_sel5, 0);
    check("n5_rst_web", web5, 0);
    pkt_valid5 = 1'b0;
    tick();
    reset5 = 1'b0;
    tick();
    check("n5_after_rst_da", da5, 1);
    check("n5_after_rst_busy", busy5, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
